// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl_pkg: shared state encoding and defaults for the clock set controller
package clock_set_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_H   = 2'd1,
        SET_M   = 2'd2,
        RELEASE = 2'd3
    } state_t;
    localparam int FAST_AFTER_DEFAULT = 4;
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: strobe, button and control-pulse bundle of the clock set controller
interface clock_set_ctrl_if;
    logic i_1hz_stb;
    logic i_timeset_stb;
    logic i_set_hours;
    logic i_set_minutes;
    logic o_run_en;
    logic o_sec_stb;
    logic o_inc_hours;
    logic o_inc_minutes;
    logic o_clr_seconds;
    logic o_fast_set;
    modport master (
        output i_1hz_stb, i_timeset_stb, i_set_hours, i_set_minutes,
        input  o_run_en, o_sec_stb, o_inc_hours, o_inc_minutes, o_clr_seconds, o_fast_set
    );
    modport slave (
        input  i_1hz_stb, i_timeset_stb, i_set_hours, i_set_minutes,
        output o_run_en, o_sec_stb, o_inc_hours, o_inc_minutes, o_clr_seconds, o_fast_set
    );
endinterface

// File: rtl/clock_set_ctrl_input_sync.sv
// input_sync: 2-flop synchronizer for one asynchronous level
module input_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven hours/minutes set FSM with fast-set request and run gating
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int FAST_AFTER = FAST_AFTER_DEFAULT
) (
    input logic i_clk,
    input logic i_reset,
    clock_set_ctrl_if.slave bus
);
    localparam int CW = $clog2(FAST_AFTER + 1);
    state_t state, next;
    logic sh, sm;
    logic [CW-1:0] cnt, cnt_d;
    logic inc_h, inc_m, inc_h_d, inc_m_d;
    logic cnt_max;

    input_sync u_sync_h (.clk(i_clk), .rst(i_reset), .d(bus.i_set_hours),   .q(sh));
    input_sync u_sync_m (.clk(i_clk), .rst(i_reset), .d(bus.i_set_minutes), .q(sm));

    assign cnt_max = cnt == CW'(FAST_AFTER);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= RUN;
            cnt   <= '0;
            inc_h <= 1'b0;
            inc_m <= 1'b0;
        end else begin
            state <= next;
            cnt   <= cnt_d;
            inc_h <= inc_h_d;
            inc_m <= inc_m_d;
        end
    end

    // Increments are decided here and registered, so a strobe in the exit cycle never steps
    always_comb begin
        next    = state;
        cnt_d   = cnt;
        inc_h_d = 1'b0;
        inc_m_d = 1'b0;
        case (state)
            RUN: begin
                if (sh) begin
                    next    = SET_H;
                    inc_h_d = 1'b1;
                    cnt_d   = '0;
                end else if (sm) begin
                    next    = SET_M;
                    inc_m_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            SET_H: begin
                if (!sh) next = RELEASE;
                else if (bus.i_timeset_stb) begin
                    inc_h_d = 1'b1;
                    cnt_d   = cnt_max ? cnt : cnt + CW'(1);
                end
            end
            SET_M: begin
                if (!sm) next = RELEASE;
                else if (bus.i_timeset_stb) begin
                    inc_m_d = 1'b1;
                    cnt_d   = cnt_max ? cnt : cnt + CW'(1);
                end
            end
            RELEASE: begin
                next  = RUN;
                cnt_d = '0;
            end
            default: next = RUN;
        endcase
    end

    assign bus.o_run_en      = state == RUN;
    assign bus.o_sec_stb     = bus.i_1hz_stb && state == RUN;
    assign bus.o_clr_seconds = state == RELEASE;
    assign bus.o_fast_set    = (state == SET_H || state == SET_M) && cnt_max;
    assign bus.o_inc_hours   = inc_h;
    assign bus.o_inc_minutes = inc_m;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int n_h, n_m, n_clr, n_fast, n_both, n_run_pulse;
    logic mon_clr = 1'b1;

    clock_set_ctrl_if bus ();
    clock_set_ctrl #(.FAST_AFTER(4)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // Pulse tallies, sampled on the inactive edge
    always @(negedge clk) begin
        if (mon_clr) begin
            n_h = 0; n_m = 0; n_clr = 0; n_fast = 0; n_both = 0; n_run_pulse = 0;
        end else begin
            if (bus.o_inc_hours) n_h++;
            if (bus.o_inc_minutes) n_m++;
            if (bus.o_clr_seconds) n_clr++;
            if (bus.o_fast_set) n_fast++;
            if (bus.o_inc_hours && bus.o_inc_minutes) n_both++;
            if (bus.o_run_en && (bus.o_inc_hours || bus.o_inc_minutes || bus.o_clr_seconds)) n_run_pulse++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe();
        bus.i_timeset_stb = 1'b1;
        tick();
        bus.i_timeset_stb = 1'b0;
    endtask

    task automatic restart_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    initial begin
        bus.i_1hz_stb = 1'b0;
        bus.i_timeset_stb = 1'b0;
        bus.i_set_hours = 1'b0;
        bus.i_set_minutes = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_run_en", int'(bus.o_run_en), 1);
        check("rst_inc_h", int'(bus.o_inc_hours), 0);
        check("rst_inc_m", int'(bus.o_inc_minutes), 0);
        check("rst_clr", int'(bus.o_clr_seconds), 0);
        check("rst_fast", int'(bus.o_fast_set), 0);
        check("run_sec_idle", int'(bus.o_sec_stb), 0);
        bus.i_1hz_stb = 1'b1;
        #1;
        check("run_sec_stb", int'(bus.o_sec_stb), 1);
        tick();
        bus.i_1hz_stb = 1'b0;

        // Minutes session: 3 strobes, latency and gating
        restart_mon();
        bus.i_set_minutes = 1'b1;
        tick();
        tick();
        check("lat_m_c2", int'(bus.o_inc_minutes), 0);
        check("lat_run_c2", int'(bus.o_run_en), 1);
        tick();
        check("lat_m_c3", int'(bus.o_inc_minutes), 1);
        check("setm_run_en", int'(bus.o_run_en), 0);
        tick();
        check("setm_pulse_1cyc", int'(bus.o_inc_minutes), 0);
        bus.i_1hz_stb = 1'b1;
        #1;
        check("setm_sec_gated", int'(bus.o_sec_stb), 0);
        bus.i_1hz_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe();
            check("setm_stb_inc", int'(bus.o_inc_minutes), 1);
            tick();
        end
        bus.i_set_minutes = 1'b0;
        repeat (5) tick();
        check("m_sess_inc_m", n_m, 4);
        check("m_sess_inc_h", n_h, 0);
        check("m_sess_clr", n_clr, 1);
        check("m_sess_fast", n_fast, 0);
        check("m_sess_run_pulse", n_run_pulse, 0);
        check("m_sess_back_run", int'(bus.o_run_en), 1);

        // Hours session: 7 strobes, fast-set after the 4th
        restart_mon();
        bus.i_set_hours = 1'b1;
        repeat (3) tick();
        for (int i = 1; i <= 7; i++) begin
            strobe();
            check($sformatf("h_fast_%0d", i), int'(bus.o_fast_set), int'(i >= 4));
            tick();
        end
        bus.i_set_hours = 1'b0;
        repeat (5) tick();
        check("h_sess_inc_h", n_h, 8);
        check("h_sess_inc_m", n_m, 0);
        check("h_sess_clr", n_clr, 1);
        check("h_sess_fast_off", int'(bus.o_fast_set), 0);

        // Both buttons together, then hand off from hours to minutes
        restart_mon();
        bus.i_set_hours = 1'b1;
        bus.i_set_minutes = 1'b1;
        repeat (3) tick();
        check("both_inc_h", int'(bus.o_inc_hours), 1);
        check("both_inc_m", int'(bus.o_inc_minutes), 0);
        repeat (2) tick();
        bus.i_set_hours = 1'b0;
        tick();
        tick();
        check("hand_seth_run", int'(bus.o_run_en), 0);
        check("hand_seth_clr", int'(bus.o_clr_seconds), 0);
        tick();
        check("hand_rel_clr", int'(bus.o_clr_seconds), 1);
        check("hand_rel_run", int'(bus.o_run_en), 0);
        tick();
        check("hand_run_run", int'(bus.o_run_en), 1);
        check("hand_run_clr", int'(bus.o_clr_seconds), 0);
        tick();
        check("hand_setm_inc", int'(bus.o_inc_minutes), 1);
        check("hand_setm_run", int'(bus.o_run_en), 0);
        tick();
        check("hand_cnt_m", n_m, 1);
        check("hand_cnt_h", n_h, 1);
        check("hand_both", n_both, 0);

        // Reset in the middle of a minutes session
        restart_mon();
        tick();
        strobe();
        check("pre_rst_inc_m", int'(bus.o_inc_minutes), 1);
        rst = 1'b1;
        #1;
        check("arst_inc_m", int'(bus.o_inc_minutes), 0);
        check("arst_run_en", int'(bus.o_run_en), 1);
        check("arst_clr", int'(bus.o_clr_seconds), 0);
        check("arst_fast", int'(bus.o_fast_set), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_c2_inc", int'(bus.o_inc_minutes), 0);
        check("post_rst_c2_run", int'(bus.o_run_en), 1);
        tick();
        check("post_rst_c3_inc", int'(bus.o_inc_minutes), 1);
        check("rst_no_clr", n_clr, 0);
        bus.i_set_minutes = 1'b0;
        repeat (5) tick();
        check("end_run_en", int'(bus.o_run_en), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
